pll_lock_ce_gen: RTL and testbench

- Parametrised lock supervisor and clock-enable generator for the DOM PLL outputs (pll4x family).
- Synchronises and qualifies the PLL's raw lock, holds a downstream synchronous reset until lock has been stable, and generates N_CH phase-aligned clock-enable strobes at per-channel divide ratios.
- Counts loss-of-lock events for slow-control readout.
- Sits directly after the PLL, in the PLL output clock domain.

---
 rtl/pll_lock_ce_gen.sv | 194 +++++++++++++++++++
 tb/tb_pll_lock_ce_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ce_gen.sv
// Lock supervisor and clock-enable generator for the PLL output domain.
// Qualifies the synchronised PLL lock, sequences the downstream reset and emits phase-aligned CE strobes.
module pll_lock_ce_gen #(
  parameter int                      N_CH     = 2,
  parameter int                      DIV_W    = 8,
  parameter logic [N_CH*DIV_W-1:0]   DIV_LIST = {8'd4, 8'd2},
  parameter int                      LOCK_CNT = 1024,
  parameter int                      RST_HOLD = 16,
  parameter int                      LOSS_W   = 8
) (
  input  logic              inclock,
  input  logic              reset,
  input  logic              locked_raw,
  input  logic              clear_lost,
  output logic              locked,
  output logic              rst_out,
  output logic [N_CH-1:0]   ce,
  output logic              lock_lost,
  output logic [LOSS_W-1:0] loss_count,
  output logic [1:0]        state_dbg
);

  localparam int CNT_MAX = (LOCK_CNT > RST_HOLD) ? LOCK_CNT : RST_HOLD;
  localparam int QW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [QW-1:0] LOCK_LAST = QW'(LOCK_CNT - 1);
  localparam logic [QW-1:0] HOLD_LAST = QW'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b00,
    ST_QUALIFY  = 2'b01,
    ST_HOLD     = 2'b10,
    ST_RUN      = 2'b11
  } state_t;

  state_t                        state_q, state_d;
  logic [QW-1:0]                 qcnt_q, qcnt_d;
  logic                          sync1_q, sync2_q;
  logic                          loss_s;
  logic                          locked_q, locked_d;
  logic                          rst_out_q, rst_out_d;
  logic [N_CH-1:0]               ce_q, ce_d;
  logic [N_CH-1:0][DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                          lock_lost_q, lock_lost_d;
  logic [LOSS_W-1:0]             loss_count_q, loss_count_d;

  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    if (v == {LOSS_W{1'b1}}) begin
      return v;
    end else begin
      return v + LOSS_W'(1'b1);
    end
  endfunction

  // Terminal count for a channel; a programmed ratio of 0 behaves as 1.
  function automatic logic [DIV_W-1:0] div_last(input int ch);
    logic [DIV_W-1:0] d;
    d = DIV_LIST[ch*DIV_W +: DIV_W];
    if (d == '0) begin
      return '0;
    end else begin
      return d - DIV_W'(1'b1);
    end
  endfunction

  // Lock FSM next state, shared qualify/hold counter and loss detection
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    loss_s  = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        qcnt_d = '0;
        if (sync2_q) begin
          state_d = ST_QUALIFY;
        end else begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_QUALIFY: begin
        if (!sync2_q) begin
          state_d = ST_UNLOCKED;
          qcnt_d  = '0;
        end else if (qcnt_q == LOCK_LAST) begin
          state_d = ST_HOLD;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + QW'(1'b1);
        end
      end
      ST_HOLD: begin
        if (!sync2_q) begin
          state_d = ST_UNLOCKED;
          qcnt_d  = '0;
          loss_s  = 1'b1;
        end else if (qcnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + QW'(1'b1);
        end
      end
      ST_RUN: begin
        qcnt_d = '0;
        if (!sync2_q) begin
          state_d = ST_UNLOCKED;
          loss_s  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        qcnt_d  = '0;
      end
    endcase
  end

  // Output decode from next state plus per-channel divider phase
  always_comb begin
    locked_d  = (state_d == ST_HOLD) || (state_d == ST_RUN);
    rst_out_d = (state_d != ST_RUN);
    ce_d      = '0;
    div_cnt_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
        div_cnt_d[i] = '0;
        ce_d[i]      = 1'b1;
      end else if (state_d == ST_RUN) begin
        if (div_cnt_q[i] >= div_last(i)) begin
          div_cnt_d[i] = '0;
        end else begin
          div_cnt_d[i] = div_cnt_q[i] + DIV_W'(1'b1);
        end
        ce_d[i] = (div_cnt_d[i] == '0);
      end else begin
        div_cnt_d[i] = '0;
        ce_d[i]      = 1'b0;
      end
    end
  end

  // Sticky loss flag and saturating counter; a loss on the clear cycle still counts once
  always_comb begin
    lock_lost_d  = lock_lost_q;
    loss_count_d = loss_count_q;
    if (clear_lost) begin
      lock_lost_d  = 1'b0;
      loss_count_d = '0;
    end else begin
      lock_lost_d  = lock_lost_q;
    end
    if (loss_s) begin
      lock_lost_d  = 1'b1;
      loss_count_d = sat_inc(loss_count_d);
    end else begin
      loss_count_d = loss_count_d;
    end
  end

  // State, synchroniser and registered outputs
  always_ff @(posedge inclock) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= ST_UNLOCKED;
      qcnt_q       <= '0;
      locked_q     <= 1'b0;
      rst_out_q    <= 1'b1;
      ce_q         <= '0;
      div_cnt_q    <= '0;
      lock_lost_q  <= 1'b0;
      loss_count_q <= '0;
    end else begin
      sync1_q      <= locked_raw;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      qcnt_q       <= qcnt_d;
      locked_q     <= locked_d;
      rst_out_q    <= rst_out_d;
      ce_q         <= ce_d;
      div_cnt_q    <= div_cnt_d;
      lock_lost_q  <= lock_lost_d;
      loss_count_q <= loss_count_d;
    end
  end

  assign locked     = locked_q;
  assign rst_out    = rst_out_q;
  assign ce         = ce_q;
  assign lock_lost  = lock_lost_q;
  assign loss_count = loss_count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pll_lock_ce_gen.sv
// Bench for pll_lock_ce_gen: directed lock/loss scenarios plus random lock traffic against a streak-based model.
module tb_pll_lock_ce_gen;

  localparam int L  = 8;
  localparam int H  = 4;
  localparam int LW = 2;
  localparam logic [15:0] DIVS_A = {8'd3, 8'd1};
  localparam logic [15:0] DIVS_B = {8'd0, 8'd2};

  logic inclock = 1'b0;
  logic reset = 1'b1, locked_raw = 1'b0, clear_lost = 1'b0;

  logic a_locked, a_rst_out, a_lock_lost;
  logic [1:0] a_ce, a_state;
  logic [LW-1:0] a_loss;
  logic b_locked, b_rst_out, b_lock_lost;
  logic [1:0] b_ce, b_state;
  logic [LW-1:0] b_loss;

  int n_checks = 0;
  int n_fail   = 0;
  // reference: synchroniser delay line, streak of consecutive lock_sync=1 edges, loss bookkeeping
  int sy1 = 0, sy2 = 0, streak = 0, m_lost = 0, m_cnt = 0;
  int first_lock, first_run, hits, hit_sum;

  pll_lock_ce_gen #(.N_CH(2), .DIV_W(8), .DIV_LIST(DIVS_A), .LOCK_CNT(L), .RST_HOLD(H), .LOSS_W(LW)) dut (
    .inclock(inclock), .reset(reset), .locked_raw(locked_raw), .clear_lost(clear_lost),
    .locked(a_locked), .rst_out(a_rst_out), .ce(a_ce), .lock_lost(a_lock_lost),
    .loss_count(a_loss), .state_dbg(a_state));

  pll_lock_ce_gen #(.N_CH(2), .DIV_W(8), .DIV_LIST(DIVS_B), .LOCK_CNT(L), .RST_HOLD(H), .LOSS_W(LW)) dut_z (
    .inclock(inclock), .reset(reset), .locked_raw(locked_raw), .clear_lost(clear_lost),
    .locked(b_locked), .rst_out(b_rst_out), .ce(b_ce), .lock_lost(b_lock_lost),
    .loss_count(b_loss), .state_dbg(b_state));

  always #5 inclock = ~inclock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int div_eff(input int which, input int ch);
    logic [15:0] v;
    int d;
    v = (which != 0) ? DIVS_B : DIVS_A;
    d = int'(v[ch*8 +: 8]);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic logic [1:0] exp_ce(input int which);
    logic [1:0] r;
    r = 2'b00;
    for (int c = 0; c < 2; c++) begin
      if (streak >= L + H + 1) begin
        r[c] = (((streak - (L + H + 1)) % div_eff(which, c)) == 0);
      end
    end
    return r;
  endfunction

  task automatic model_edge();
    int ls;
    bit loss;
    if (reset) begin
      sy1 = 0; sy2 = 0; streak = 0; m_lost = 0; m_cnt = 0;
    end else begin
      ls     = sy2;
      loss   = (ls == 0) && (streak >= L + 1);
      streak = (ls != 0) ? streak + 1 : 0;
      sy2    = sy1;
      sy1    = int'(locked_raw);
      if (clear_lost) begin
        m_lost = 0; m_cnt = 0;
      end
      if (loss) begin
        m_lost = 1;
        if (m_cnt < (1 << LW) - 1) m_cnt++;
      end
    end
  endtask

  task automatic check_all();
    logic [1:0] st;
    logic lk, rs;
    lk = (streak >= L + 1);
    rs = (streak < L + H + 1);
    st = (streak == 0) ? 2'd0 : (streak <= L) ? 2'd1 : (streak <= L + H) ? 2'd2 : 2'd3;
    check_val("a_locked", 32'(a_locked), 32'(lk));
    check_val("a_rst_out", 32'(a_rst_out), 32'(rs));
    check_val("a_state", 32'(a_state), 32'(st));
    check_val("a_ce", 32'(a_ce), 32'(exp_ce(0)));
    check_val("a_lock_lost", 32'(a_lock_lost), 32'(m_lost));
    check_val("a_loss_count", 32'(a_loss), 32'(m_cnt));
    check_val("b_state", 32'(b_state), 32'(st));
    check_val("b_ce", 32'(b_ce), 32'(exp_ce(1)));
  endtask

  task automatic tick(input logic raw, input logic clr, input logic rst);
    locked_raw = raw;
    clear_lost = clr;
    reset      = rst;
    @(posedge inclock);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    // scenario 1: clean lock from reset
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check_val("rst_locked", 32'(a_locked), 32'd0);
    check_val("rst_rst_out", 32'(a_rst_out), 32'd1);
    first_lock = 0; first_run = 0; hits = 0; hit_sum = 0;
    for (int e = 1; e <= 22; e++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (a_locked && first_lock == 0) first_lock = e;
      if (!a_rst_out && first_run == 0) first_run = e;
      if (a_ce[1]) begin hits++; hit_sum += e; end
    end
    check_val("s1_lock_edge", 32'(first_lock), 32'd11);
    check_val("s1_run_edge", 32'(first_run), 32'd15);
    check_val("s1_ce1_hits", 32'(hits), 32'd3);
    check_val("s1_ce1_edge_sum", 32'(hit_sum), 32'd54);

    // scenario 2: two-cycle dropout during qualification
    tick(1'b0, 1'b0, 1'b1);
    first_lock = 0;
    for (int e = 1; e <= 24; e++) begin
      tick((e == 5 || e == 6) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      if (a_locked && first_lock == 0) first_lock = e;
    end
    check_val("s2_lock_edge", 32'(first_lock), 32'd17);
    check_val("s2_no_loss", 32'(a_loss), 32'd0);
    check_val("s2_no_lost", 32'(a_lock_lost), 32'd0);

    // scenario 3: lock drop in RUN
    check_val("s3_in_run", 32'(a_state), 32'd3);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_val("s3_still_locked", 32'(a_locked), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    check_val("s3_locked", 32'(a_locked), 32'd0);
    check_val("s3_rst_out", 32'(a_rst_out), 32'd1);
    check_val("s3_ce", 32'(a_ce), 32'd0);
    check_val("s3_lost", 32'(a_lock_lost), 32'd1);
    check_val("s3_count", 32'(a_loss), 32'd1);

    // scenario 4: saturation, then clear coinciding with a loss
    tick(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      repeat (16) tick(1'b1, 1'b0, 1'b0);
      repeat (3) tick(1'b0, 1'b0, 1'b0);
    end
    check_val("s4_saturated", 32'(a_loss), 32'd3);
    repeat (16) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check_val("s4_clear_loss_cnt", 32'(a_loss), 32'd1);
    check_val("s4_clear_loss_flag", 32'(a_lock_lost), 32'd1);
    tick(1'b0, 1'b1, 1'b0);
    check_val("s4_clear_cnt", 32'(a_loss), 32'd0);
    check_val("s4_clear_flag", 32'(a_lock_lost), 32'd0);

    // scenario 5: reset during HOLD, then relock with identical timing
    tick(1'b0, 1'b0, 1'b1);
    repeat (12) tick(1'b1, 1'b0, 1'b0);
    check_val("s5_in_hold", 32'(a_state), 32'd2);
    tick(1'b1, 1'b0, 1'b1);
    check_val("s5_state", 32'(a_state), 32'd0);
    check_val("s5_locked", 32'(a_locked), 32'd0);
    check_val("s5_rst_out", 32'(a_rst_out), 32'd1);
    first_lock = 0; first_run = 0;
    for (int e = 1; e <= 15; e++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (a_locked && first_lock == 0) first_lock = e;
      if (!a_rst_out && first_run == 0) first_run = e;
    end
    check_val("s5_lock_edge", 32'(first_lock), 32'd11);
    check_val("s5_run_edge", 32'(first_run), 32'd15);

    // scenario 6: zero divide ratio acts as divide-by-one
    hits = (b_ce[1] ? 1 : 0);
    for (int e = 0; e < 6; e++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (b_ce[1]) hits++;
    end
    check_val("s6_div0_hits", 32'(hits), 32'd7);

    // random lock traffic with sporadic clears and resets
    for (int seg = 0; seg < 80; seg++) begin
      logic raw;
      int len;
      raw = ($urandom_range(0, 3) != 0);
      len = (raw) ? $urandom_range(1, 24) : $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        tick(raw, ($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
